// File: rtl/omsp_uspi_pkg.sv
// Shared definitions for the byte-wide SPI master: register offsets,
// CTRL bit positions, FSM states and the prescale helper.
package omsp_uspi_pkg;

  // Word offsets from the peripheral base (CTRL at base+0, DATA at base+2 bytes)
  localparam logic [13:0] CTRL_OFF = 14'd0;
  localparam logic [13:0] DATA_OFF = 14'd1;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_DIV   = 4;
  localparam int CTRL_IE    = 6;
  localparam int CTRL_SSEL  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  // Terminal count of the tick counter for a half-period of 2^div ticks
  function automatic logic [2:0] half_lim(input logic [1:0] div);
    case (div)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/omsp_uspi_if.sv
// openMSP430 peripheral bus slice used by the SPI master.
interface omsp_uspi_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/omsp_uspi_clkdiv.sv
// Half-period timer: counts ticks (every cycle or SMCLK-qualified) and
// pulses half_o on the last tick of each 2^div-tick half period.
module omsp_uspi_clkdiv
  import omsp_uspi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       run_i,
  input  logic       ssel_i,
  input  logic       smclk_en_i,
  input  logic [1:0] div_i,
  output logic       half_o
);

  logic [2:0] cnt_q, cnt_d;
  logic       tick;

  assign tick   = ~ssel_i | smclk_en_i;
  assign half_o = run_i & tick & (cnt_q == half_lim(div_i));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || half_o)    cnt_d = '0;
    else if (run_i && tick) cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/omsp_uspi.sv
// Byte-wide SPI master (mode 0, MSB first) on the openMSP430 peripheral bus.
// CTRL/DATA registers, shift FSM and completion interrupt.
module omsp_uspi
  import omsp_uspi_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0090
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        smclk_en,
  input  logic        spi_miso,
  omsp_uspi_if.slave  bus,
  output logic        spi_irq_tx_done,
  output logic        spi_mosi,
  output logic        spi_clk
);

  localparam logic [13:0] CTRL_ADDR = BASE_ADDR[14:1] + CTRL_OFF;
  localparam logic [13:0] DATA_ADDR = BASE_ADDR[14:1] + DATA_OFF;

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        bitbuf_q, bitbuf_d;
  logic        done_q, done_d;
  logic [1:0]  div_q, div_d;
  logic        ie_q, ie_d;
  logic        ssel_q, ssel_d;

  logic        sel_ctrl, sel_data, wr, rd, busy, start, half;
  logic [7:0]  ctrl_rd;
  logic [15:0] dout;
  logic        unused;

  assign sel_ctrl = bus.per_addr == CTRL_ADDR;
  assign sel_data = bus.per_addr == DATA_ADDR;
  assign wr       = bus.per_en & bus.per_we[0];
  assign rd       = bus.per_en & (bus.per_we == 2'b00);
  assign busy     = state_q != ST_IDLE;
  assign start    = wr & sel_ctrl & bus.per_din[CTRL_START] & ~busy;
  assign unused   = ^bus.per_din[15:8];

  omsp_uspi_clkdiv u_clkdiv (
    .clk_i      (mclk),
    .rst_ni     (puc_rst),
    .clr_i      (start),
    .run_i      (busy),
    .ssel_i     (ssel_q),
    .smclk_en_i (smclk_en),
    .div_i      (div_q),
    .half_o     (half)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    bitbuf_d = bitbuf_q;
    done_d   = done_q;
    div_d    = div_q;
    ie_d     = ie_q;
    ssel_d   = ssel_q;

    // Config bits follow every CTRL write, even mid-transfer
    if (wr && sel_ctrl) begin
      div_d  = bus.per_din[CTRL_DIV +: 2];
      ie_d   = bus.per_din[CTRL_IE];
      ssel_d = bus.per_din[CTRL_SSEL];
      if (bus.per_din[CTRL_DONE]) done_d = 1'b0;
    end
    if (wr && sel_data && !busy) shreg_d = bus.per_din[7:0];

    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_LOW;
        bitcnt_d = '0;
        done_d   = 1'b0;
      end
      ST_LOW: if (half) begin
        state_d  = ST_HIGH;
        bitbuf_d = spi_miso;
      end
      ST_HIGH: if (half) begin
        shreg_d = {shreg_q[6:0], bitbuf_q};
        if (bitcnt_q == 3'd7) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_LOW;
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst) begin
    if (!puc_rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      bitbuf_q <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      ie_q     <= 1'b0;
      ssel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      bitbuf_q <= bitbuf_d;
      done_q   <= done_d;
      div_q    <= div_d;
      ie_q     <= ie_d;
      ssel_q   <= ssel_d;
    end
  end

  assign ctrl_rd = {ssel_q, ie_q, div_q, 1'b0, done_q, busy, 1'b0};

  always_comb begin
    dout = '0;
    if (rd && sel_ctrl)      dout[7:0] = ctrl_rd;
    else if (rd && sel_data) dout[7:0] = shreg_q;
  end

  assign bus.per_dout     = dout;
  assign spi_clk          = state_q == ST_HIGH;
  assign spi_mosi         = shreg_q[7];
  assign spi_irq_tx_done  = done_q & ie_q;

endmodule

// File: tb/tb_omsp_uspi.sv
// Bench for omsp_uspi: table of directed transfers, randomized transfers,
// all checked cycle by cycle against a tick-count model of the SPI waveform.
module tb_omsp_uspi;
  import omsp_uspi_pkg::*;

  localparam logic [13:0] A_CTRL = 14'h0048;
  localparam logic [13:0] A_DATA = 14'h0049;

  typedef struct {
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [1:0]  div;
    logic        ssel;
    logic        ie;
    int          per;      // smclk_en period, 0 = random
    int          wr_at;    // cycle offset of an injected write, -1 = none
    logic [13:0] wr_a;
    logic [7:0]  wr_v;
    logic [15:0] exp_ctrl;
    logic [15:0] exp_data;
  } vec_t;

  logic mclk = 1'b0;
  logic puc_rst, smclk_en, spi_miso;
  logic irq, mosi, sclk;
  int   n_chk = 0;
  int   n_fail = 0;

  omsp_uspi_if u_if ();

  omsp_uspi #(.BASE_ADDR(15'h0090)) dut (
    .mclk            (mclk),
    .puc_rst         (puc_rst),
    .smclk_en        (smclk_en),
    .spi_miso        (spi_miso),
    .bus             (u_if),
    .spi_irq_tx_done (irq),
    .spi_mosi        (mosi),
    .spi_clk         (sclk)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bus_wr(input logic [13:0] a, input logic [7:0] d);
    @(negedge mclk);
    u_if.per_addr = a; u_if.per_din = {8'h00, d}; u_if.per_we = 2'b01; u_if.per_en = 1'b1;
    @(negedge mclk);
    u_if.per_en = 1'b0; u_if.per_we = 2'b00;
  endtask

  task automatic bus_rd(input logic [13:0] a, output logic [15:0] d);
    @(negedge mclk);
    u_if.per_addr = a; u_if.per_we = 2'b00; u_if.per_en = 1'b1;
    #1 d = u_if.per_dout;
    u_if.per_en = 1'b0;
  endtask

  // Model: after t ticks of a transfer with half-period h, half index t/h
  // selects clock level (odd = high) and bit (t/2h) on mosi; done after 16h ticks.
  task automatic run_xfer(input vec_t v, input string nm);
    int h, total, t, hidx;
    int unsigned r;
    logic [2:0]  exp_pins;
    logic [15:0] rdv;
    logic        done_seen;
    h = 1 << v.div;
    total = 16 * h;
    t = 0;
    done_seen = 1'b0;
    smclk_en = 1'b0;
    bus_wr(A_DATA, v.tx);
    spi_miso = v.rx[7];
    bus_wr(A_CTRL, {v.ssel, v.ie, v.div, 4'b0001});
    for (int k = 0; k < 4000; k++) begin
      hidx = t / h;
      if (t < total) exp_pins = {hidx[0], v.tx[7 - hidx / 2], 1'b0};
      else           exp_pins = {1'b0, v.rx[7], v.ie};
      chk($sformatf("%s clk/mosi/irq k%0d", nm, k), {13'd0, sclk, mosi, irq}, {13'd0, exp_pins});
      if (t >= total) begin
        done_seen = 1'b1;
        break;
      end
      spi_miso = v.rx[7 - hidx / 2];
      r = $urandom_range(0, 1);
      if (v.ssel && v.per > 0) smclk_en = (k % v.per) == 0;
      else                     smclk_en = r[0];
      if (!v.ssel || smclk_en) t++;
      if (k == v.wr_at) begin
        u_if.per_addr = v.wr_a; u_if.per_din = {8'h00, v.wr_v};
        u_if.per_we = 2'b01; u_if.per_en = 1'b1;
      end else if (k == v.wr_at + 1) begin
        u_if.per_en = 1'b0; u_if.per_we = 2'b00;
      end
      @(negedge mclk);
    end
    u_if.per_en = 1'b0; u_if.per_we = 2'b00;
    smclk_en = 1'b0;
    chk({nm, " completed"}, {15'd0, done_seen}, 16'd1);
    bus_rd(A_CTRL, rdv);
    chk({nm, " ctrl"}, rdv, v.exp_ctrl);
    bus_rd(A_DATA, rdv);
    chk({nm, " data"}, rdv, v.exp_data);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] rdv;
    vec_t        tbl[5];
    vec_t        v;

    u_if.per_addr = '0; u_if.per_din = '0; u_if.per_en = 1'b0; u_if.per_we = 2'b00;
    puc_rst = 1'b0; smclk_en = 1'b0; spi_miso = 1'b0;

    //             tx     rx     div   ssel  ie    per wr_at wr_a    wr_v   ctrl      data
    tbl[0] = '{8'hAD, 8'hFF, 2'd0, 1'b0, 1'b1, 0, -1, A_CTRL, 8'h00, 16'h0044, 16'h00FF};
    tbl[1] = '{8'h7F, 8'h3C, 2'd0, 1'b0, 1'b0, 0, -1, A_CTRL, 8'h00, 16'h0004, 16'h003C};
    tbl[2] = '{8'h5A, 8'h96, 2'd1, 1'b0, 1'b1, 0, 10, A_DATA, 8'h00, 16'h0054, 16'h0096};
    tbl[3] = '{8'hC3, 8'h0F, 2'd0, 1'b0, 1'b0, 0,  7, A_CTRL, 8'h01, 16'h0004, 16'h000F};
    tbl[4] = '{8'h3C, 8'hA5, 2'd2, 1'b1, 1'b0, 3, -1, A_CTRL, 8'h00, 16'h00A4, 16'h00A5};

    repeat (2) @(negedge mclk);
    chk("in reset pins", {13'd0, sclk, mosi, irq}, 16'd0);
    puc_rst = 1'b1;
    @(negedge mclk);
    chk("idle pins", {13'd0, sclk, mosi, irq}, 16'd0);
    chk("dout no access", u_if.per_dout, 16'd0);
    bus_rd(A_CTRL, rdv);  chk("reset ctrl", rdv, 16'd0);
    bus_rd(A_DATA, rdv);  chk("reset data", rdv, 16'd0);

    for (int i = 0; i < 5; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    bus_rd(14'h004A, rdv);  chk("unmapped read", rdv, 16'd0);

    for (int i = 0; i < 6; i++) begin
      v.tx = 8'($urandom); v.rx = 8'($urandom);
      v.div = 2'($urandom_range(0, 3));
      v.ssel = 1'($urandom_range(0, 1)); v.ie = 1'($urandom_range(0, 1));
      v.per = 0; v.wr_at = -1; v.wr_a = A_CTRL; v.wr_v = 8'h00;
      v.exp_ctrl = {8'h00, v.ssel, v.ie, v.div, 4'b0100};
      v.exp_data = {8'h00, v.rx};
      run_xfer(v, $sformatf("rand%0d", i));
    end

    // Reset in the middle of a transfer, while spi_clk is high and mosi=1
    bus_wr(A_DATA, 8'hFF);
    bus_wr(A_CTRL, 8'h41);
    repeat (3) @(negedge mclk);
    chk("pre-reset pins", {13'd0, sclk, mosi, irq}, 16'h0006);
    puc_rst = 1'b0;
    #1 chk("mid-xfer reset pins", {13'd0, sclk, mosi, irq}, 16'd0);
    @(negedge mclk);
    puc_rst = 1'b1;
    bus_rd(A_CTRL, rdv);  chk("post-reset ctrl", rdv, 16'd0);
    bus_rd(A_DATA, rdv);  chk("post-reset data", rdv, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/omsp_uspi.md
# omsp_uspi

Byte-wide SPI master peripheral on the openMSP430 peripheral bus. Software loads a transmit byte, sets START, and the block shifts 8 bits out on `spi_mosi` while capturing 8 bits from `spi_miso` (SPI mode 0, MSB first). When the transfer completes, the received byte replaces the data register and an optional completion interrupt is raised.

## Interface
- `BASE_ADDR`, 15'h0090: byte base address. CTRL is at base+0 (per_addr 14'h0048); DATA is at base+2 (per_addr 14'h0049).
- `mclk` in 1: single clock; all logic is on the rising edge.
- `puc_rst` in 1: reset, asynchronous and active-low.
- `per_addr` in 14: word address.
- `per_din` in 16: write data; only bits [7:0] are used.
- `per_en` in 1: peripheral access strobe.
- `per_we` in 2: byte write enables. Registers are written only when `per_we[0]`=1. `per_we`=0 means a read.
- `smclk_en` in 1: SMCLK tick, used as the bit-timing source when SSEL=1.
- `spi_miso` in 1: serial input.
- `spi_irq_tx_done` out 1: interrupt level, equal to DONE & IE.
- `spi_mosi` out 1: serial output.
- `spi_clk` out 1: SPI clock, idles low.
- `per_dout` out 16: read data. It is 0 unless a read of this block is in progress. Bits [15:8] are always 0.

## Operation
- CTRL (reset 0x00):
  - [0] START: write 1 to begin a transfer. Reads 0.
  - [1] BUSY: read-only.
  - [2] DONE: set at end of transfer. Cleared by writing 1, or by START.
  - [3] reserved, reads 0.
  - [5:4] DIV: half-period = 2^DIV ticks.
  - [6] IE: interrupt enable.
  - [7] SSEL: 0 = every mclk cycle is a tick; 1 = only cycles with smclk_en=1 are ticks.
- DATA (reset 0x00):
  - Writes load the shift register, but only when BUSY=0; writes while BUSY=1 are ignored.
  - Reads return the shift register, which holds the received byte after completion.
- A START write while BUSY=1 updates DIV/IE/SSEL only; it does not restart the transfer.
- Transfer sequence:
  - Drive the MSB on `spi_mosi`.
  - After H ticks, raise `spi_clk` and sample `spi_miso` into a bit buffer.
  - After H more ticks, lower `spi_clk`, shift the register left inserting the sampled bit, and present the next MSB.
  - Repeat for 8 bits, then go idle.
- State machine: IDLE → SHIFT (8 bit-phases, each with a HIGH and a LOW half) → IDLE.
- On completion: BUSY=0 and DONE=1, both in the same cycle as the final falling edge.
- Idle outputs: `spi_clk`=0; `spi_mosi` holds DATA[7].

## Timing
- The START write is in cycle N. BUSY=1, `spi_mosi`=bit7, and the divider counter is cleared, all effective at cycle N+1.
- With DIV=0 and SSEL=0: `spi_clk` period is 2 mclk cycles. Rising edges occur at N+2, N+4, …, N+16.
  - BUSY falls and DONE/irq rise at N+17.
  - DATA holds the received byte from N+17.
- General case: the transfer takes 16·2^DIV ticks.
- `per_dout` is combinational from the current `per_addr`/`per_en`, with zero wait states.
- Reset mid-transfer: all registers return to 0 immediately, `spi_clk` goes to 0, and `spi_mosi` goes to 0.
- START with DONE=1 and IE=1: the irq drops at N+1.

## Structure
- The shared package `omsp_uspi_pkg` holds:
  - register offsets
  - CTRL bit positions
  - the state enum
- One sub-module, `omsp_uspi_clkdiv`, is natural: it is a tick/half-period counter with selectable prescale.
- Register decode, the shifter, and the FSM stay in the top level.

## Test plan
- Reset then idle: `spi_clk`=0, `spi_mosi`=0, irq=0. Reads of CTRL and DATA both return 0x0000.
- Write DATA=0xAD, CTRL=0x41, with miso held at 1:
  - MOSI is 1,0,1,0,1,1,0,1 across 8 `spi_clk` pulses of 2-cycle period.
  - At N+17: irq=1, CTRL reads 0x44, DATA reads 0xFF.
- Then write DATA=0x7F, CTRL=0x01:
  - irq drops at N+1.
  - MOSI is 0 followed by seven 1s.
  - At the end: DONE=1 but irq stays 0; CTRL reads 0x04.
- Write DATA during BUSY: the value is ignored and the transfer continues. A second START while BUSY does not restart.
- Write DIV=2 with SSEL=1 and smclk_en pulsing every 3 cycles: `spi_clk` half-period is 4 ticks (12 mclk cycles). Received byte is 0xA5 when miso is driven with the 0xA5 pattern.
- Assert reset mid-transfer: outputs go to 0 immediately. After release: BUSY=0, DONE=0.
